// File: rtl/dds_cmd_handler_mc.sv
// Multi-channel DDS command handler: shadow/active config regs with synchronous commit.
// Optional DDS_CMD_LEN_CHECK_EN drops bad-length commands and counts them.
module dds_cmd_handler_mc #(
  parameter int          NUM_CH       = 4,
  parameter int          FREQ_W       = 32,
  parameter int          PHASE_W      = 32,
  parameter int          WAVE_W       = 3,
  parameter int          AMP_W        = 12,
  parameter logic [7:0]  CFG_TYPE     = 8'hFD,
  parameter logic [7:0]  SYNC_TYPE    = 8'hFE,
  parameter logic [31:0] DEFAULT_FREQ = 32'd21474836
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                cmd_type,
  input  logic [15:0]               cmd_length,
  input  logic [7:0]                cmd_data,
  input  logic [15:0]               cmd_data_index,
  input  logic                      cmd_start,
  input  logic                      cmd_data_valid,
  input  logic                      cmd_done,
  output logic                      cmd_ready,
  output logic [NUM_CH*WAVE_W-1:0]  wave_type,
  output logic [NUM_CH*FREQ_W-1:0]  freq_word,
  output logic [NUM_CH*PHASE_W-1:0] phase_word,
  output logic [NUM_CH*AMP_W-1:0]   amp_word,
  output logic [NUM_CH-1:0]         cfg_update,
  output logic [NUM_CH-1:0]         phase_sync,
  output logic [NUM_CH-1:0]         pending
`ifdef DDS_CMD_LEN_CHECK_EN
  ,
  output logic [7:0]                err_count,
  output logic                      err_pulse
`endif
);

  localparam int BUF_N = 13;

  typedef enum logic [2:0] {
    S_IDLE, S_RECV_CFG, S_RECV_SYNC, S_APPLY_CFG, S_APPLY_SYNC
  } state_t;

  state_t r_state, w_next;

  logic [7:0]         r_buf [BUF_N];
  logic [WAVE_W-1:0]  r_sh_wave  [NUM_CH];
  logic [FREQ_W-1:0]  r_sh_freq  [NUM_CH];
  logic [PHASE_W-1:0] r_sh_phase [NUM_CH];
  logic [AMP_W-1:0]   r_sh_amp   [NUM_CH];
  logic [WAVE_W-1:0]  r_ac_wave  [NUM_CH];
  logic [FREQ_W-1:0]  r_ac_freq  [NUM_CH];
  logic [PHASE_W-1:0] r_ac_phase [NUM_CH];
  logic [AMP_W-1:0]   r_ac_amp   [NUM_CH];
  logic [NUM_CH-1:0]  r_pend, r_upd, r_psync;

  logic               w_accept, w_recv, w_go;
  logic               w_do_cfg, w_do_sync, w_commit;
  logic [NUM_CH-1:0]  w_mask;
  logic [WAVE_W-1:0]  w_wave;
  logic [FREQ_W-1:0]  w_freq;
  logic [PHASE_W-1:0] w_phase;
  logic [AMP_W-1:0]   w_amp;
  logic               w_unused;

  assign w_accept = (r_state == S_IDLE) && cmd_start &&
                    ((cmd_type == CFG_TYPE) || (cmd_type == SYNC_TYPE));
  assign w_recv   = (r_state == S_RECV_CFG) || (r_state == S_RECV_SYNC);
  assign w_mask   = r_buf[0][NUM_CH-1:0];
  assign w_wave   = r_buf[1][WAVE_W-1:0];
  assign w_freq   = FREQ_W'({r_buf[2], r_buf[3], r_buf[4], r_buf[5]});
  assign w_phase  = PHASE_W'({r_buf[6], r_buf[7], r_buf[8], r_buf[9]});
  assign w_amp    = AMP_W'({r_buf[10], r_buf[11]});
  assign w_commit = r_buf[12][0];
  assign w_unused = ^{cmd_length, r_buf[0], r_buf[1], r_buf[10], r_buf[12]};

`ifdef DDS_CMD_LEN_CHECK_EN
  logic [15:0] r_len;
  logic [7:0]  r_err_cnt;
  logic        r_err_p;
  logic        w_apply;

  assign w_apply   = (r_state == S_APPLY_CFG) || (r_state == S_APPLY_SYNC);
  assign w_go      = (r_state == S_APPLY_CFG) ? (r_len == 16'd13)
                                              : (r_len == 16'd1);
  assign err_count = r_err_cnt;
  assign err_pulse = r_err_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_err_cnt <= '0;
      r_err_p   <= 1'b0;
    end else begin
      if (w_accept) r_len <= cmd_length;
      r_err_p <= w_apply && !w_go;
      if (w_apply && !w_go && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`else
  assign w_go = 1'b1;
`endif

  assign w_do_cfg  = (r_state == S_APPLY_CFG)  && w_go;
  assign w_do_sync = (r_state == S_APPLY_SYNC) && w_go;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (cmd_type == CFG_TYPE) ? S_RECV_CFG : S_RECV_SYNC;
      end
      S_RECV_CFG:   if (cmd_done) w_next = S_APPLY_CFG;
      S_RECV_SYNC:  if (cmd_done) w_next = S_APPLY_SYNC;
      S_APPLY_CFG:  w_next = S_IDLE;
      S_APPLY_SYNC: w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state != S_APPLY_CFG) && (r_state != S_APPLY_SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_N; i++) r_buf[i] <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_sh_wave[n]  <= '0;
        r_sh_freq[n]  <= DEFAULT_FREQ[FREQ_W-1:0];
        r_sh_phase[n] <= '0;
        r_sh_amp[n]   <= '1;
        r_ac_wave[n]  <= '0;
        r_ac_freq[n]  <= DEFAULT_FREQ[FREQ_W-1:0];
        r_ac_phase[n] <= '0;
        r_ac_amp[n]   <= '1;
      end
      r_pend  <= '0;
      r_upd   <= '0;
      r_psync <= '0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < BUF_N; i++) r_buf[i] <= '0;
      end else if (w_recv && cmd_data_valid && (cmd_data_index < 16'd13)) begin
        r_buf[cmd_data_index[3:0]] <= cmd_data;
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (w_do_cfg && w_mask[n]) begin
          r_sh_wave[n]  <= w_wave;
          r_sh_freq[n]  <= w_freq;
          r_sh_phase[n] <= w_phase;
          r_sh_amp[n]   <= w_amp;
          r_pend[n]     <= !w_commit;
          if (w_commit) begin
            r_ac_wave[n]  <= w_wave;
            r_ac_freq[n]  <= w_freq;
            r_ac_phase[n] <= w_phase;
            r_ac_amp[n]   <= w_amp;
          end
        end
        // all masked channels load on this one edge for a coherent start
        if (w_do_sync && w_mask[n]) begin
          r_ac_wave[n]  <= r_sh_wave[n];
          r_ac_freq[n]  <= r_sh_freq[n];
          r_ac_phase[n] <= r_sh_phase[n];
          r_ac_amp[n]   <= r_sh_amp[n];
          r_pend[n]     <= 1'b0;
        end
      end
      r_upd   <= ((w_do_cfg && w_commit) || w_do_sync) ? w_mask : '0;
      r_psync <= ((w_do_cfg && w_commit) || w_do_sync) ? w_mask : '0;
    end
  end

  always_comb begin
    wave_type  = '0;
    freq_word  = '0;
    phase_word = '0;
    amp_word   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      wave_type[n*WAVE_W +: WAVE_W]    = r_ac_wave[n];
      freq_word[n*FREQ_W +: FREQ_W]    = r_ac_freq[n];
      phase_word[n*PHASE_W +: PHASE_W] = r_ac_phase[n];
      amp_word[n*AMP_W +: AMP_W]       = r_ac_amp[n];
    end
  end

  assign cfg_update = r_upd;
  assign phase_sync = r_psync;
  assign pending    = r_pend;

endmodule

// File: tb/tb_dds_cmd_handler_mc.sv
// Bench for dds_cmd_handler_mc: vector table driven through a reference model
// and scoreboard, plus reset-abort and length-check sequences.
module tb_dds_cmd_handler_mc;

  localparam int NCH = 4;
  localparam int WW  = 3;
  localparam int AW  = 12;
  localparam logic [7:0]  CFG  = 8'hFD;
  localparam logic [7:0]  SYNC = 8'hFE;
  localparam logic [31:0] DEFF = 32'd21474836;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        cmd_type, cmd_data;
  logic [15:0]       cmd_length, cmd_data_index;
  logic              cmd_start, cmd_data_valid, cmd_done;
  logic              cmd_ready;
  logic [NCH*WW-1:0] wave_type;
  logic [NCH*32-1:0] freq_word, phase_word;
  logic [NCH*AW-1:0] amp_word;
  logic [NCH-1:0]    cfg_update, phase_sync, pending;
`ifdef DDS_CMD_LEN_CHECK_EN
  logic [7:0]        err_count;
  logic              err_pulse;
`endif

  always #5 clk = ~clk;

  dds_cmd_handler_mc #(
    .NUM_CH(NCH), .FREQ_W(32), .PHASE_W(32), .WAVE_W(WW), .AMP_W(AW),
    .CFG_TYPE(CFG), .SYNC_TYPE(SYNC), .DEFAULT_FREQ(DEFF)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_type(cmd_type), .cmd_length(cmd_length),
    .cmd_data(cmd_data), .cmd_data_index(cmd_data_index),
    .cmd_start(cmd_start), .cmd_data_valid(cmd_data_valid),
    .cmd_done(cmd_done), .cmd_ready(cmd_ready),
    .wave_type(wave_type), .freq_word(freq_word),
    .phase_word(phase_word), .amp_word(amp_word),
    .cfg_update(cfg_update), .phase_sync(phase_sync),
    .pending(pending)
`ifdef DDS_CMD_LEN_CHECK_EN
    , .err_count(err_count), .err_pulse(err_pulse)
`endif
  );

  typedef struct {
    logic [7:0]  typ;
    logic [7:0]  mask;
    logic [7:0]  wave;
    logic [31:0] freq;
    logic [31:0] phase;
    logic [15:0] amp;
    logic        commit;
    int          nbytes;
    logic [15:0] len;
    logic        same_done;
  } vec_t;

  typedef struct packed {
    logic [NCH*WW-1:0] wave;
    logic [NCH*32-1:0] freq;
    logic [NCH*32-1:0] phase;
    logic [NCH*AW-1:0] amp;
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    upd;
    logic              rdy;
    logic [7:0]        err;
    logic              errp;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  logic [WW-1:0] m_sw[NCH], m_aw[NCH];
  logic [31:0]   m_sf[NCH], m_af[NCH], m_sp[NCH], m_ap[NCH];
  logic [AW-1:0] m_sa[NCH], m_aa[NCH];
  logic [NCH-1:0] m_pend;
  int            m_err;
  logic [7:0]    m_buf[13];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_sw[n] = '0; m_aw[n] = '0;
      m_sf[n] = DEFF; m_af[n] = DEFF;
      m_sp[n] = '0; m_ap[n] = '0;
      m_sa[n] = '1; m_aa[n] = '1;
    end
    m_pend = '0;
    m_err  = 0;
  endtask

  function automatic exp_t pack_model();
    exp_t e;
    e = '0;
    for (int n = 0; n < NCH; n++) begin
      e.wave[n*WW +: WW]  = m_aw[n];
      e.freq[n*32 +: 32]  = m_af[n];
      e.phase[n*32 +: 32] = m_ap[n];
      e.amp[n*AW +: AW]   = m_aa[n];
    end
    e.pend = m_pend;
    e.rdy  = 1'b1;
    e.err  = 8'(m_err);
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    chk({tag, ".wave"},  128'(wave_type),  128'(e.wave));
    chk({tag, ".freq"},  128'(freq_word),  128'(e.freq));
    chk({tag, ".phase"}, 128'(phase_word), 128'(e.phase));
    chk({tag, ".amp"},   128'(amp_word),   128'(e.amp));
    chk({tag, ".pend"},  128'(pending),    128'(e.pend));
    chk({tag, ".upd"},   128'(cfg_update), 128'(e.upd));
    chk({tag, ".psync"}, 128'(phase_sync), 128'(e.upd));
`ifdef DDS_CMD_LEN_CHECK_EN
    chk({tag, ".errcnt"}, 128'(err_count), 128'(e.err));
    chk({tag, ".errp"},   128'(err_pulse), 128'(e.errp));
`endif
  endtask

  task automatic idle_inputs();
    cmd_type = 8'h00; cmd_length = 16'd0; cmd_data = 8'h00;
    cmd_data_index = 16'd0; cmd_start = 1'b0;
    cmd_data_valid = 1'b0; cmd_done = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [7:0] p[13];
    logic [NCH-1:0] mk, upd;
    logic acc, drop;
    logic [15:0] a16;
    exp_t e;
    for (int i = 0; i < 13; i++) p[i] = 8'h00;
    p[0] = v.mask;
    if (v.typ != SYNC) begin
      p[1] = v.wave;
      {p[2], p[3], p[4], p[5]} = v.freq;
      {p[6], p[7], p[8], p[9]} = v.phase;
      {p[10], p[11]} = v.amp;
      p[12] = {7'd0, v.commit};
    end
    acc  = (v.typ == CFG) || (v.typ == SYNC);
    upd  = '0;
    drop = 1'b0;
    if (acc) begin
      for (int i = 0; i < 13; i++) m_buf[i] = (i < v.nbytes) ? p[i] : 8'h00;
`ifdef DDS_CMD_LEN_CHECK_EN
      drop = (v.typ == CFG) ? (v.len != 16'd13) : (v.len != 16'd1);
      if (drop && m_err < 255) m_err++;
`endif
      mk = m_buf[0][NCH-1:0];
      if (!drop) begin
        for (int n = 0; n < NCH; n++) begin
          if (mk[n] && v.typ == CFG) begin
            m_sw[n] = m_buf[1][WW-1:0];
            m_sf[n] = {m_buf[2], m_buf[3], m_buf[4], m_buf[5]};
            m_sp[n] = {m_buf[6], m_buf[7], m_buf[8], m_buf[9]};
            a16 = {m_buf[10], m_buf[11]};
            m_sa[n] = a16[AW-1:0];
            if (m_buf[12][0]) begin
              m_aw[n] = m_sw[n]; m_af[n] = m_sf[n];
              m_ap[n] = m_sp[n]; m_aa[n] = m_sa[n];
              m_pend[n] = 1'b0; upd[n] = 1'b1;
            end else begin
              m_pend[n] = 1'b1;
            end
          end
          if (mk[n] && v.typ == SYNC) begin
            m_aw[n] = m_sw[n]; m_af[n] = m_sf[n];
            m_ap[n] = m_sp[n]; m_aa[n] = m_sa[n];
            m_pend[n] = 1'b0; upd[n] = 1'b1;
          end
        end
      end
    end
    e = pack_model();
    e.upd  = upd;
    e.rdy  = !acc;
    e.errp = drop;
    sb.push_back(e);

    @(negedge clk);
    cmd_type = v.typ; cmd_length = v.len; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_data = 8'hFF; cmd_data_index = 16'd13; cmd_data_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < v.nbytes; i++) begin
      cmd_data = p[i]; cmd_data_index = 16'(i); cmd_data_valid = 1'b1;
      if (acc && i == 3) begin
        cmd_start = 1'b1; cmd_type = (v.typ == CFG) ? SYNC : CFG;
      end
      if (v.same_done && i == v.nbytes - 1) cmd_done = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; cmd_type = v.typ;
    end
    cmd_data_valid = 1'b0;
    if (!v.same_done) begin
      cmd_done = 1'b1;
      @(negedge clk);
    end
    cmd_done = 1'b0;
    chk({tag, ".rdy_apply"}, 128'(cmd_ready), 128'(e.rdy));
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s.sb: got empty scoreboard expected entry", tag);
    end else begin
      compare_all(tag, sb.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, ".upd_off"},   128'(cfg_update), 128'(0));
    chk({tag, ".psync_off"}, 128'(phase_sync), 128'(0));
    chk({tag, ".rdy_back"},  128'(cmd_ready),  128'(1));
  endtask

  vec_t vecs[10];
  exp_t e0;

  initial begin
    vecs[0] = '{CFG,  8'h05, 8'd2,  32'h0100_0000, 32'h4000_0000, 16'h0800, 1'b0, 13, 16'd13, 1'b0};
    vecs[1] = '{SYNC, 8'h0F, 8'd0,  32'h0,         32'h0,         16'h0,    1'b0, 1,  16'd1,  1'b0};
    vecs[2] = '{CFG,  8'h02, 8'd1,  32'h0000_1000, 32'h0000_0000, 16'h0123, 1'b1, 13, 16'd13, 1'b0};
    vecs[3] = '{8'h10, 8'hFF, 8'd3, 32'hDEAD_BEEF, 32'h1234_5678, 16'h0777, 1'b1, 13, 16'd13, 1'b0};
    vecs[4] = '{CFG,  8'hF0, 8'd4,  32'hCAFE_F00D, 32'h1111_2222, 16'h0333, 1'b1, 13, 16'd13, 1'b0};
    vecs[5] = '{CFG,  8'h0A, 8'd7,  32'h89AB_CDEF, 32'h0F0F_0F0F, 16'h0456, 1'b1, 13, 16'd13, 1'b1};
    vecs[6] = '{CFG,  8'h08, 8'd5,  32'hAABB_CCDD, 32'h5555_5555, 16'h0999, 1'b1, 6,  16'd6,  1'b0};
    vecs[7] = '{SYNC, 8'h08, 8'd0,  32'h0,         32'h0,         16'h0,    1'b0, 1,  16'd1,  1'b0};
    vecs[8] = '{CFG,  8'h1F, 8'hFF, 32'h0000_0042, 32'h8000_0001, 16'hFABC, 1'b1, 13, 16'd13, 1'b0};
    vecs[9] = '{SYNC, 8'h00, 8'd0,  32'h0,         32'h0,         16'h0,    1'b0, 1,  16'd1,  1'b0};

    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    e0 = pack_model();
    compare_all("reset", e0);
    chk("reset.rdy", 128'(cmd_ready), 128'(1));

    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // abort a CFG mid-payload with reset
    @(negedge clk);
    cmd_type = CFG; cmd_length = 16'd13; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 8'h0F; cmd_data_index = 16'(i); cmd_data_valid = 1'b1;
      @(negedge clk);
    end
    cmd_data_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    e0 = pack_model();
    compare_all("midrst", e0);
    chk("midrst.rdy", 128'(cmd_ready), 128'(1));
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all("midrst.done", e0);
    run_vec("recover", vecs[2]);

`ifdef DDS_CMD_LEN_CHECK_EN
    begin
      vec_t bad;
      bad = vecs[2];
      bad.len = 16'd12;
      run_vec("lenbad", bad);
      for (int k = 0; k < 256; k++) run_vec("lensat", bad);
      chk("lensat.final", 128'(err_count), 128'(255));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dds_cmd_handler_mc.md
Name: dds_cmd_handler_mc

Overview:
- Multi-channel DDS command handler; successor to the dual-channel DAC handler.
- Decodes configuration and sync commands from the command bus into per-channel shadow registers.
- Commits shadow to active registers on command, for any channel subset at once.
- Active registers drive external DDS cores. Adds amplitude, channel-mask broadcast, synchronous multi-channel commit and phase-sync pulses.

Parameters:
NUM_CH, 4, number of channels (1..8)
FREQ_W, 32, frequency word width (<=32)
PHASE_W, 32, phase word width (<=32)
WAVE_W, 3, wave type width (<=8)
AMP_W, 12, amplitude width (<=16)
CFG_TYPE, 8'hFD, cmd_type of configuration command
SYNC_TYPE, 8'hFE, cmd_type of commit/sync command
DEFAULT_FREQ, 21474836, reset frequency word

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_type  in  8  command type, valid with cmd_start
cmd_length  in  16  payload length in bytes
cmd_data  in  8  payload byte
cmd_data_index  in  16  byte index of cmd_data
cmd_start  in  1  command start strobe
cmd_data_valid  in  1  payload byte strobe
cmd_done  in  1  end-of-command strobe
cmd_ready  out  1  handler accepting command traffic
wave_type  out  NUM_CH*WAVE_W  active wave type; channel n at [n*WAVE_W +: WAVE_W]
freq_word  out  NUM_CH*FREQ_W  active frequency words
phase_word  out  NUM_CH*PHASE_W  active phase words
amp_word  out  NUM_CH*AMP_W  active amplitude words
cfg_update  out  NUM_CH  one-cycle pulse per channel whose active regs changed
phase_sync  out  NUM_CH  one-cycle pulse: DDS must reload phase accumulator
pending  out  NUM_CH  shadow written but not yet committed

Behaviour:
- One clock; reset synchronous, active-high (rst sampled on posedge clk).
- Reset values, shadow and active: wave 0, freq DEFAULT_FREQ, phase 0, amp all-ones. Also: state IDLE; cmd_ready 1; cfg_update, phase_sync, pending 0; buffer zeroed.
- Reset mid-command: aborts the command, nothing is committed, all outputs return to reset values.
- States: IDLE, RECV_CFG, RECV_SYNC, APPLY_CFG, APPLY_SYNC. cmd_ready=1 in IDLE/RECV_*, 0 in APPLY_*.
- IDLE: cmd_start with cmd_type==CFG_TYPE -> RECV_CFG; ==SYNC_TYPE -> RECV_SYNC; any other type ignored. The 13-byte buffer is zeroed on the accepted cmd_start edge.
- RECV_*: cmd_data_valid with index<13 writes buffer[index]; index>=13 ignored. cmd_start while receiving ignored. cmd_done -> APPLY_CFG/APPLY_SYNC. cmd_data_valid and cmd_done in the same cycle: the byte is stored first.
- CFG payload, big-endian multi-byte fields, low bits used when width<32:
  - byte0: channel mask; bits >= NUM_CH ignored.
  - byte1: wave type.
  - bytes2-5: frequency word.
  - bytes6-9: phase word.
  - bytes10-11: amplitude word.
  - byte12 bit0: commit immediately.
- APPLY_CFG (one cycle, then IDLE):
  - Every masked channel's shadow takes the fields; masked channels all get identical values.
  - If commit bit=0: pending[n] set for masked channels.
  - If commit bit=1: active also written on the same edge, pending[n] cleared, cfg_update[n] and phase_sync[n] pulse.
- SYNC payload: byte0 = channel mask.
- APPLY_SYNC: active<=shadow for all masked channels on one edge (phase-coherent start); pending cleared; cfg_update and phase_sync pulse for masked channels even when shadow==active.
- Mask 0 or all-out-of-range: no register change, no pulses, returns to IDLE.
- Latency: cmd_done sampled at edge k -> active/shadow/pulses visible after edge k+1; pulses high exactly one cycle; cmd_ready back high after edge k+1.
- Short payload: missing bytes read as 0 (buffer zeroed at start).

Optional Feature:
- Macro DDS_CMD_LEN_CHECK_EN.
- Defined:
  - APPLY drops the command (no writes, no pulses) if cmd_length != 13 for CFG or != 1 for SYNC.
  - Adds output err_count [7:0]: increments per dropped command, saturates at 255, reset 0.
  - Adds output err_pulse (one cycle on each drop).
- Not defined: no length checking; short/long payloads apply per the zero-fill/ignore rules; err_count and err_pulse ports absent.

Test Plan:
- Reset -> freq_word every channel 21474836, amp 12'hFFF, wave 0, phase 0, cmd_ready 1, pending 0.
- CFG mask 8'h05, wave 2, freq 32'h0100_0000, phase 32'h4000_0000, amp 12'h800, commit 0 -> pending=4'b0101, active unchanged, no pulses.
- Then SYNC mask 8'h0F -> ch0/ch2 active take new values on one edge; cfg_update=phase_sync=4'b1111 for exactly one cycle; pending=0.
- CFG mask 8'h02 commit 1, freq 32'h0000_1000 -> ch1 active freq 32'h0000_1000 at done+2 edges; cfg_update=4'b0010; pending[1]=0.
- cmd_type 8'h10 full command, then CFG mask 8'hF0 (NUM_CH=4) -> no register change, no pulses, cmd_ready stays high after.
- With DDS_CMD_LEN_CHECK_EN: CFG cmd_length 12 -> no change, err_pulse once, err_count 1; 256 bad commands -> err_count 255.
